// File: rtl/test_value_uart_tx.sv
// Debug reporter: whenever the core's test_value changes, send it over a UART
// line as four uppercase hex digits followed by CR LF (8N1, LSB first).
module test_value_uart_tx #(
    parameter int CLK_DIV = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] test_value,
    input  logic        send_en,
    output logic        tx,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_baud_cnt, w_baud_cnt_nxt;
    logic [2:0]  r_bit_idx, w_bit_idx_nxt;
    logic [2:0]  r_char_idx, w_char_idx_nxt;
    logic [15:0] r_ref_value, w_ref_value_nxt;
    logic [15:0] r_prev_value;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_overrun;
    logic [15:0] r_frame_count, w_frame_count_nxt;
    logic [3:0]  w_nibble;
    logic [7:0]  w_char;
    logic        w_bit_end;

    // Character currently being serialised, derived from the frozen snapshot.
    always_comb begin
        case (r_char_idx)
            3'd0:    w_nibble = r_ref_value[15:12];
            3'd1:    w_nibble = r_ref_value[11:8];
            3'd2:    w_nibble = r_ref_value[7:4];
            default: w_nibble = r_ref_value[3:0];
        endcase
        if (r_char_idx == 3'd4)
            w_char = 8'h0D;
        else if (r_char_idx == 3'd5)
            w_char = 8'h0A;
        else if (w_nibble < 4'd10)
            w_char = 8'h30 + {4'h0, w_nibble};
        else
            w_char = 8'h37 + {4'h0, w_nibble};
    end

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        w_state_nxt       = r_state;
        w_baud_cnt_nxt    = r_baud_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_char_idx_nxt    = r_char_idx;
        w_ref_value_nxt   = r_ref_value;
        w_tx_nxt          = r_tx;
        w_busy_nxt        = r_busy;
        w_frame_count_nxt = r_frame_count;

        if (r_state != S_IDLE)
            w_baud_cnt_nxt = w_bit_end ? 16'd0 : r_baud_cnt + 16'd1;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (send_en && (test_value != r_ref_value)) begin
                    w_ref_value_nxt = test_value;
                    w_char_idx_nxt  = 3'd0;
                    w_baud_cnt_nxt  = 16'd0;
                    w_state_nxt     = S_START;
                    w_tx_nxt        = 1'b0;
                    w_busy_nxt      = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = w_char[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = w_char[r_bit_idx + 3'd1];
                    end
                end
            end
            S_STOP: begin
                // Last stop bit closes the frame; otherwise the next start bit follows with no gap.
                if (w_bit_end) begin
                    if (r_char_idx == 3'd5) begin
                        w_state_nxt       = S_IDLE;
                        w_busy_nxt        = 1'b0;
                        w_tx_nxt          = 1'b1;
                        w_frame_count_nxt = r_frame_count + 16'd1;
                    end else begin
                        w_char_idx_nxt = r_char_idx + 3'd1;
                        w_state_nxt    = S_START;
                        w_tx_nxt       = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_baud_cnt    <= 16'd0;
            r_bit_idx     <= 3'd0;
            r_char_idx    <= 3'd0;
            r_ref_value   <= 16'h0000;
            r_prev_value  <= 16'h0000;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_baud_cnt    <= w_baud_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_char_idx    <= w_char_idx_nxt;
            r_ref_value   <= w_ref_value_nxt;
            r_prev_value  <= test_value;
            r_tx          <= w_tx_nxt;
            r_busy        <= w_busy_nxt;
            r_overrun     <= r_busy && (test_value != r_prev_value);
            r_frame_count <= w_frame_count_nxt;
        end
    end

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Bench for test_value_uart_tx: frame-level reference model plus a UART receiver
// that decodes the serial line into bytes for literal frame checks.
module tb_test_value_uart_tx;

    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_en = 1'b0;
    logic [15:0] test_value = 16'h0000;
    logic        tx;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_count;
    logic [1:0]  dbg_state;

    test_value_uart_tx #(.CLK_DIV(CD)) dut (
        .clk        (clk),
        .reset      (reset),
        .test_value (test_value),
        .send_en    (send_en),
        .tx         (tx),
        .busy       (busy),
        .overrun    (overrun),
        .frame_count(frame_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is the per-cycle line waveform of six 8N1 characters.
    logic        m_tx   = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_ovr  = 1'b0;
    logic [15:0] m_ref  = 16'h0000;
    logic [15:0] m_prev = 16'h0000;
    logic [15:0] m_fc   = 16'h0000;
    logic [0:0]  exp_q[$];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return "0" + {4'h0, n};
        return "A" + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_frame(input logic [15:0] v);
        logic [7:0] chars [6];
        chars[0] = hex_char(v[15:12]);
        chars[1] = hex_char(v[11:8]);
        chars[2] = hex_char(v[7:4]);
        chars[3] = hex_char(v[3:0]);
        chars[4] = 8'h0D;
        chars[5] = 8'h0A;
        for (int c = 0; c < 6; c++) begin
            repeat (CD) exp_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) repeat (CD) exp_q.push_back(chars[c][b]);
            repeat (CD) exp_q.push_back(1'b1);
        end
    endtask

    // Receiver and monitors.
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    int         rx_err = 0;
    int         ovr_cnt = 0;
    int         busy_len = 0;
    int         last_busy_len = 0;
    int         busy_cycles = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_tx = 1'b1; m_busy = 1'b0; m_ovr = 1'b0;
            m_ref = 16'h0000; m_prev = 16'h0000; m_fc = 16'h0000;
            exp_q.delete();
        end else begin
            m_ovr  = m_busy && (test_value != m_prev);
            m_prev = test_value;
            if (m_busy) begin
                if (exp_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_tx   = 1'b1;
                    m_fc   = m_fc + 16'd1;
                end else begin
                    m_tx = exp_q.pop_front();
                end
            end else if (send_en && (test_value != m_ref)) begin
                m_ref = test_value;
                push_frame(test_value);
                m_busy = 1'b1;
                m_tx   = exp_q.pop_front();
            end
        end
        #1;
        check("tx", 32'(tx), 32'(m_tx));
        check("busy", 32'(busy), 32'(m_busy));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("frame_count", 32'(frame_count), 32'(m_fc));

        if (overrun === 1'b1) ovr_cnt++;
        if (busy === 1'b1) begin
            busy_len++;
            busy_cycles++;
        end else if (busy_len != 0) begin
            last_busy_len = busy_len;
            busy_len = 0;
        end

        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            for (int i = 0; i < 8; i++)
                if (rx_cnt == CD * (1 + i) + CD / 2) rx_byte[i] = tx;
            if (rx_cnt == CD * 9 + CD / 2) begin
                if (tx !== 1'b1) rx_err++;
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    end

    task automatic wait_frame(input string name);
        int t = 0;
        while (busy !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        while (busy === 1'b1 && t < 20 + 60 * CD + 20) begin @(negedge clk); t++; end
        check({name, " frame end"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_frame(input string name, input logic [47:0] exp_bytes);
        check({name, " byte count"}, 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check(name, 32'(b), 32'(exp_bytes[47 - 8 * i -: 8]));
        end
        rx_q.delete();
    endtask

    initial begin
        int b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_en = 1'b1;

        // Idle with value equal to reset snapshot: no activity.
        ovr_cnt = 0;
        repeat (500) @(negedge clk);
        check("s1 tx", 32'(tx), 32'd1);
        check("s1 busy", 32'(busy), 32'd0);
        check("s1 frame_count", 32'(frame_count), 32'd0);
        check("s1 overrun count", 32'(ovr_cnt), 32'd0);
        check("s1 rx bytes", 32'(rx_q.size()), 32'd0);

        // 1A3F, with two collapsed changes during the frame.
        test_value = 16'h1A3F;
        @(posedge clk); #1;
        check("s2 start tx", 32'(tx), 32'd0);
        check("s2 start busy", 32'(busy), 32'd1);
        repeat (50) @(negedge clk);
        test_value = 16'h0002;
        repeat (30) @(negedge clk);
        test_value = 16'h0003;
        wait_frame("s2");
        check("s2 busy length", 32'(last_busy_len), 32'd240);
        check_frame("s2 bytes", 48'h31_41_33_46_0D_0A);
        check("s2 frame_count", 32'(frame_count), 32'd1);
        check("s3 overrun count", 32'(ovr_cnt), 32'd2);
        ovr_cnt = 0;
        wait_frame("s3");
        check_frame("s3 bytes", 48'h30_30_30_33_0D_0A);
        check("s3 frame_count", 32'(frame_count), 32'd2);
        check("s3 overrun count", 32'(ovr_cnt), 32'd0);

        // Reporting disabled, then enabled.
        send_en = 1'b0;
        test_value = 16'hC0DE;
        b0 = busy_cycles;
        repeat (300) @(negedge clk);
        check("s4 busy cycles", 32'(busy_cycles - b0), 32'd0);
        check("s4 rx bytes", 32'(rx_q.size()), 32'd0);
        send_en = 1'b1;
        @(posedge clk); #1;
        check("s4 start tx", 32'(tx), 32'd0);
        check("s4 start busy", 32'(busy), 32'd1);
        wait_frame("s4");
        check_frame("s4 bytes", 48'h43_30_44_45_0D_0A);
        check("s4 frame_count", 32'(frame_count), 32'd3);

        // Reset in the middle of char 2.
        test_value = 16'h1234;
        @(posedge clk); #1;
        check("s5 start busy", 32'(busy), 32'd1);
        repeat (2 * 10 * CD + 10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("s5 reset tx", 32'(tx), 32'd1);
        check("s5 reset busy", 32'(busy), 32'd0);
        check("s5 reset frame_count", 32'(frame_count), 32'd0);
        repeat (3) @(negedge clk);
        test_value = 16'hBEEF;
        rx_q.delete();
        rx_err = 0;
        reset = 1'b0;
        wait_frame("s5");
        check_frame("s5 bytes", 48'h42_45_45_46_0D_0A);
        check("s5 frame_count", 32'(frame_count), 32'd1);
        check("s5 framing errors", 32'(rx_err), 32'd0);

        // frame_count wrap.
        force dut.r_frame_count = 16'hFFFF;
        m_fc = 16'hFFFF;
        @(negedge clk);
        check("s6 preload", 32'(frame_count), 32'h0000FFFF);
        release dut.r_frame_count;
        test_value = 16'h0001;
        wait_frame("s6");
        check_frame("s6 bytes", 48'h30_30_30_31_0D_0A);
        check("s6 frame_count wrap", 32'(frame_count), 32'd0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/test_value_uart_tx.md
Name: test_value_uart_tx

Overview:
Debug reporter that sits directly downstream of the MIPS core and consumes its 16-bit test_value output. When test_value changes, the block serialises the new value over a UART line as a 6-character ASCII frame: 4 uppercase hex digits, then CR, then LF. It lets a board or bench observe core progress without a waveform viewer. Intermediate values that change while a frame is in flight are collapsed, and each collapsed change is flagged.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
test_value  input  16  value from the MIPS core; synchronous to clk.
send_en  input  1  1 = reporting enabled; sampled only in IDLE.
tx  output  1  UART serial line, 8N1, idle high.
busy  output  1  1 while a frame is in flight.
overrun  output  1  one-cycle pulse per change of test_value seen while busy.
frame_count  output  16  number of completed frames; wraps.

Behaviour:
- Reset (async, immediate): tx=1, busy=0, overrun=0, frame_count=0, ref_value=16'h0000, prev_value=16'h0000, FSM=IDLE, all counters=0.
- ref_value holds the last value reported. prev_value holds test_value registered every cycle.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0.
  - Start condition, checked at a rising edge: IDLE, send_en=1, and test_value != ref_value.
  - On that edge: ref_value <= test_value, char_idx <= 0, FSM <= START, busy=1 and tx=0 from that edge. Latency from detect to start bit is one edge.
- Character sequence (char_idx 0..5): nibbles [15:12], [11:8], [7:4], [3:0], then 8'h0D, then 8'h0A.
  - Nibble encoding: 0-9 -> 8'h30+n; A-F -> 8'h37+n, giving 8'h41..8'h46.
- Per character:
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each.
  - STOP: tx=1 for CLK_DIV cycles.
  - One character = 10*CLK_DIV cycles. One frame = 60*CLK_DIV cycles.
- Characters are sent back to back: the STOP bit of char k is followed immediately by the START bit of char k+1, with no gap.
- The baud counter counts 0..CLK_DIV-1. A bit ends at the edge where the counter equals CLK_DIV-1, and the counter then reloads to 0.
- Frame end: on the edge ending the STOP bit of char 5, FSM <= IDLE, busy <= 0, frame_count <= frame_count+1. frame_count wraps from 16'hFFFF to 16'h0000.
  - At least one IDLE cycle with tx=1 separates consecutive frames.
- Changes during a frame:
  - overrun=1 for exactly one cycle on each edge where busy=1 and test_value != prev_value.
  - The snapshot in ref_value is transmitted unchanged.
  - After the frame, if the current test_value != ref_value, a new frame sends the current value. Intermediate values are not queued.
  - A change on the same edge that ends a frame (busy still 1 at that edge) counts as overrun.
- send_en=0 mid-frame: the frame completes; no new frame starts until send_en=1.
- Reset mid-frame: tx returns to 1 immediately and the frame is abandoned (no partial completion). After release, any test_value != 0 triggers a fresh frame from char 0.
- The tx, busy and overrun outputs are registered (glitch-free).

Test Plan:
(All scenarios use CLK_DIV=4: 40 cycles per character, 240 cycles per frame. The bench includes a UART receiver model.)
1. Reset, then test_value=16'h0000 and send_en=1 for 500 cycles -> tx constant 1, busy=0, frame_count=0, overrun never 1.
2. Set test_value=16'h1A3F -> start bit one edge later; receiver decodes 8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A; busy high for exactly 240 cycles; frame_count=1.
3. During the scenario-2 frame, drive test_value 16'h0002 then 16'h0003 (held) -> overrun pulses twice, each one cycle; the frame still reads "1A3F"; next frame reads "0003"; frame_count=2.
4. Set send_en=0, then test_value=16'hC0DE for 300 cycles -> no activity. Then set send_en=1 -> frame "C0DE" starts one edge later.
5. Assert reset during char 2 of frame "1234" -> tx=1 immediately, busy=0, frame_count=0. Release with test_value=16'hBEEF -> full frame "BEEF\r\n" received; no corrupted byte decoded.
6. Preload frame_count to 16'hFFFF via a sequence of short frames, or force it in the bench, then complete one frame -> frame_count=16'h0000.
